// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and constants for the add_sequencer slice.
// Holds the sequencer state encoding, the default settle time and the
// width of the settle countdown.
package add_seq_pkg;

  // Default number of cycles the external ripple adder is given to settle.
  localparam int SETTLE_CYCLES_DEFAULT = 2;

  // The countdown width covers the legal settle range 1..15.
  localparam int SETTLE_CNT_W = 4;

  // Sequencer states: waiting for operands, waiting for the adder, presenting result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } seq_state_e;

  // Value loaded into the countdown on accept; the capture happens when it reaches zero,
  // so a settle time of N cycles needs a starting count of N-1.
  function automatic logic [SETTLE_CNT_W-1:0] settle_load_value(input int cycles);
    int v;
    v = cycles - 1;
    return v[SETTLE_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter that flags when the adder has had
// enough cycles to settle. Holds at zero once expired.
module settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             count,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  // Countdown register: load wins over decrement, and the count never wraps below zero.
  // NOTE: asynchronous reset goes in the sensitivity list so the counter clears without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state is always written with non-blocking assignments so every
      // flop samples the pre-edge values, independent of block evaluation order.
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (count && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/add_sequencer.sv
// add_sequencer: accepts one operand pair at a time, drives it to an
// external ripple adder, waits SETTLE_CYCLES for the carry chain to settle,
// captures the adder's sum and internal carries, and holds them until the
// downstream consumer takes them. No arithmetic is done here.
// Optional feature: define ADD_SEQUENCER_STATS_EN to add a saturating
// 16-bit op_count output counting completed output handshakes.
module add_sequencer
  import add_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  // Upstream operand interface
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  // External ripple adder interface
  output logic [DATA_WIDTH-1:0] add_a,
  output logic [DATA_WIDTH-1:0] add_b,
  input  logic [DATA_WIDTH:0]   add_sum,
  input  logic [DATA_WIDTH-1:0] add_cout_int,
  // Downstream result interface
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out_sum,
  output logic [DATA_WIDTH-1:0] out_carries
`ifdef ADD_SEQUENCER_STATS_EN
  ,
  output logic [15:0]           op_count
`endif
);

  localparam logic [SETTLE_CNT_W-1:0] LP_SETTLE_LOAD = settle_load_value(SETTLE_CYCLES);

  seq_state_e            r_state;
  seq_state_e            w_next_state;
  logic                  w_load;
  logic                  w_count_en;
  logic                  w_capture;
  logic                  w_out_hs;
  logic                  w_timer_done;

  logic [DATA_WIDTH-1:0] r_add_a;
  logic [DATA_WIDTH-1:0] r_add_b;
  logic [DATA_WIDTH:0]   r_out_sum;
  logic [DATA_WIDTH-1:0] r_out_carries;

  // Handshake qualifiers derived directly from the state register.
  // in_ready is masked by reset so it reads low for the whole reset pulse.
  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = (r_state == HOLD);
  assign w_out_hs  = out_valid && out_ready;

  // Countdown that paces the SETTLE phase.
  settle_timer #(
    .CNT_W (SETTLE_CNT_W)
  ) u_settle_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .load_value (LP_SETTLE_LOAD),
    .count      (w_count_en),
    .done       (w_timer_done)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control strobes; one transaction in flight at a time.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    w_next_state = r_state;
    w_load       = 1'b0;
    w_count_en   = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load       = 1'b1;
          w_next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (w_timer_done) begin
          w_capture    = 1'b1;
          w_next_state = HOLD;
        end else begin
          w_count_en = 1'b1;
        end
      end
      HOLD: begin
        if (w_out_hs) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Operand registers feeding the adder; they only change on accept, so they
  // stay steady through SETTLE and HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_add_a <= '0;
      r_add_b <= '0;
    end else if (w_load) begin
      r_add_a <= in_a;
      r_add_b <= in_b;
    end
  end

  // Result registers: snapshot of the adder outputs once the carry chain has settled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_sum     <= '0;
      r_out_carries <= '0;
    end else if (w_capture) begin
      r_out_sum     <= add_sum;
      r_out_carries <= add_cout_int;
    end
  end

  assign add_a       = r_add_a;
  assign add_b       = r_add_b;
  assign out_sum     = r_out_sum;
  assign out_carries = r_out_carries;

`ifdef ADD_SEQUENCER_STATS_EN
  logic [15:0] r_op_count;

  // Completed-transaction counter, saturating rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_count <= '0;
    end else if (w_out_hs && (r_op_count != 16'hFFFF)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_add_sequencer.sv
// tb_add_sequencer: self-checking bench for add_sequencer with a ripple
// adder attached (DATA_WIDTH=8, SETTLE_CYCLES=2). Expected values come from
// plain-arithmetic reference functions. Define ADD_SEQUENCER_STATS_EN to
// also exercise op_count.
`timescale 1ns/1ps
module tb_add_sequencer;

  localparam int DW = 8;
  localparam int SC = 2;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic [DW:0]   add_sum;
  logic [DW-1:0] add_cout_int;
  logic          out_valid;
  logic          out_ready;
  logic [DW:0]   out_sum;
  logic [DW-1:0] out_carries;
`ifdef ADD_SEQUENCER_STATS_EN
  logic [15:0]   op_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  add_sequencer #(
    .DATA_WIDTH    (DW),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sum      (add_sum),
    .add_cout_int (add_cout_int),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carries  (out_carries)
`ifdef ADD_SEQUENCER_STATS_EN
    ,
    .op_count     (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bit-serial ripple adder standing in for the external datapath.
  function automatic logic [2*DW:0] ripple(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic          c;
    logic [DW-1:0] cy;
    logic [DW:0]   s;
    c = 1'b0;
    for (int i = 0; i < DW; i++) begin
      s[i]  = a[i] ^ b[i] ^ c;
      c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      cy[i] = c;
    end
    s[DW] = c;
    return {cy, s};
  endfunction

  assign {add_cout_int, add_sum} = ripple(add_a, add_b);

  // Reference model: sum by plain addition, carry into bit i+1 recovered from a^b^sum.
  function automatic logic [DW:0] model_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [DW-1:0] model_carries(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    logic [DW:0] x;
    s = model_sum(a, b);
    x = s ^ {1'b0, a} ^ {1'b0, b};
    return x[DW:1];
  endfunction

  // Present a pair until accepted (bounded); returns at the negedge after the accept edge.
  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, output bit accepted);
    accepted = 1'b0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Count further edges until out_valid is seen; -1 if the budget expires.
  task automatic wait_valid(input int budget, output int edges);
    edges = 0;
    while (!out_valid && edges < budget) begin
      @(negedge clk);
      edges++;
    end
    if (!out_valid) edges = -1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if ({add_a, add_b} !== '0) begin n_fail++; $display("FAIL reset_add_ops: got %h expected 0", {add_a, add_b}); end
    n_checks++;
    if ({out_sum, out_carries} !== '0) begin n_fail++; $display("FAIL reset_results: got %h expected 0", {out_sum, out_carries}); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_known_vectors();
    logic [DW-1:0] va[2];
    logic [DW-1:0] vb[2];
    logic [DW:0]   es[2];
    logic [DW-1:0] ec[2];
    bit            acc;
    int            edges;
    va[0] = 8'h0F; vb[0] = 8'h01; es[0] = 9'h010; ec[0] = 8'h0F;
    va[1] = 8'hFF; vb[1] = 8'h01; es[1] = 9'h100; ec[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      send_pair(va[k], vb[k], acc);
      n_checks++;
      if (!acc) begin n_fail++; $display("FAIL known_accept[%0d]: got 0 expected 1", k); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL known_early_valid[%0d]: got %b expected 0", k, out_valid); end
      n_checks++;
      if ({add_a, add_b} !== {va[k], vb[k]}) begin n_fail++; $display("FAIL known_add_ops[%0d]: got %h expected %h", k, {add_a, add_b}, {va[k], vb[k]}); end
      wait_valid(10, edges);
      n_checks++;
      if (edges != SC) begin n_fail++; $display("FAIL known_latency[%0d]: got %0d expected %0d", k, edges, SC); end
      n_checks++;
      if (out_sum !== es[k] || es[k] !== model_sum(va[k], vb[k])) begin n_fail++; $display("FAIL known_sum[%0d]: got %h expected %h", k, out_sum, es[k]); end
      n_checks++;
      if (out_carries !== ec[k] || ec[k] !== model_carries(va[k], vb[k])) begin n_fail++; $display("FAIL known_carries[%0d]: got %h expected %h", k, out_carries, ec[k]); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL known_release[%0d]: got valid=%b ready=%b expected valid=0 ready=1", k, out_valid, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int edges;
    int bad_sum, bad_ready, bad_ops;
    send_pair(8'h12, 8'h34, acc);
    wait_valid(10, edges);
    n_checks++;
    if (!acc || edges != SC) begin n_fail++; $display("FAIL bp_start: got acc=%0d edges=%0d expected acc=1 edges=%0d", acc, edges, SC); end
    bad_sum = 0; bad_ready = 0; bad_ops = 0;
    in_valid = 1'b1;
    in_a     = 8'h77;
    in_b     = 8'h88;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_sum !== 9'h046 || out_carries !== model_carries(8'h12, 8'h34)) bad_sum++;
      if (in_ready !== 1'b0) bad_ready++;
      if ({add_a, add_b} !== 16'h1234) bad_ops++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad_sum != 0) begin n_fail++; $display("FAIL bp_hold_sum: got %0d bad cycles (last sum %h) expected 0 (sum 046)", bad_sum, out_sum); end
    n_checks++;
    if (bad_ready != 0) begin n_fail++; $display("FAIL bp_in_ready: got %0d cycles ready expected 0", bad_ready); end
    n_checks++;
    if (bad_ops != 0) begin n_fail++; $display("FAIL bp_ignore_in_valid: got %0d cycles changed (add %h) expected 0", bad_ops, {add_a, add_b}); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_settle();
    bit acc;
    int edges;
    int spurious;
    send_pair(8'hAA, 8'h55, acc);
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got valid=%b ready=%b expected 0 0", out_valid, in_ready); end
    n_checks++;
    if ({add_a, add_b, out_sum, out_carries} !== '0) begin n_fail++; $display("FAIL rst_mid_zero: got %h expected 0", {add_a, add_b, out_sum, out_carries}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready); end
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin n_fail++; $display("FAIL rst_mid_dropped: got %0d valid cycles expected 0", spurious); end
    send_pair(8'h01, 8'h01, acc);
    wait_valid(10, edges);
    n_checks++;
    if (!acc || edges != SC || out_sum !== 9'h002) begin n_fail++; $display("FAIL rst_mid_next_op: got sum=%h edges=%0d expected sum=002 edges=%0d", out_sum, edges, SC); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] va[4];
    logic [DW-1:0] vb[4];
    int            k;
    int            t_prev;
    for (int i = 0; i < 4; i++) begin
      va[i] = DW'($urandom);
      vb[i] = DW'($urandom);
    end
    k         = 0;
    t_prev    = 0;
    out_ready = 1'b1;
    in_a      = va[0];
    in_b      = vb[0];
    in_valid  = 1'b1;
    for (int n = 0; n < 60 && k < 4; n++) begin
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (out_sum !== model_sum(va[k], vb[k])) begin n_fail++; $display("FAIL b2b_sum[%0d]: got %h expected %h", k, out_sum, model_sum(va[k], vb[k])); end
        if (k > 0) begin
          n_checks++;
          if (cyc - t_prev != SC + 2) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", k, cyc - t_prev, SC + 2); end
        end
        t_prev = cyc;
        k++;
        if (k < 4) begin
          in_a = va[k];
          in_b = vb[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (k != 4) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 4", k); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] a, b;
    bit            acc;
    int            edges;
    int            stall;
    int            bad;
    for (int t = 0; t < 8; t++) begin
      a = DW'($urandom);
      b = DW'($urandom);
      send_pair(a, b, acc);
      wait_valid(10, edges);
      n_checks++;
      if (!acc || edges != SC) begin n_fail++; $display("FAIL rand_latency[%0d]: got acc=%0d edges=%0d expected 1 %0d", t, acc, edges, SC); end
      n_checks++;
      if (out_sum !== model_sum(a, b) || out_carries !== model_carries(a, b)) begin
        n_fail++;
        $display("FAIL rand_result[%0d]: got %h/%h expected %h/%h", t, out_sum, out_carries, model_sum(a, b), model_carries(a, b));
      end
      stall = $urandom_range(0, 3);
      bad   = 0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_sum !== model_sum(a, b)) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL rand_stall[%0d]: got %0d bad cycles expected 0", t, bad); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

`ifdef ADD_SEQUENCER_STATS_EN
  task automatic test_stats();
    bit acc;
    int edges;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (op_count !== 16'd0) begin n_fail++; $display("FAIL stats_after_reset: got %0d expected 0", op_count); end
    for (int i = 0; i < 5; i++) begin
      send_pair(DW'($urandom), DW'($urandom), acc);
      wait_valid(10, edges);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    n_checks++;
    if (op_count !== 16'd5) begin n_fail++; $display("FAIL stats_count: got %0d expected 5", op_count); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (op_count !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d expected 0", op_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_reset_mid_settle();
    test_back_to_back();
    test_random();
`ifdef ADD_SEQUENCER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/add_sequencer.md
ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2 (legal 1..15), cycles allowed for the downstream ripple adder to settle.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream operand pair valid.
REQ-006 SHALL have port in_ready, output, 1, sequencer can accept an operand pair.
REQ-007 SHALL have ports in_a and in_b, input, DATA_WIDTH each, operands.
REQ-008 SHALL have ports add_a and add_b, output, DATA_WIDTH each, registered operands driven to the ripple adder.
REQ-009 SHALL have port add_sum, input, DATA_WIDTH+1, adder sum including final carry.
REQ-010 SHALL have port add_cout_int, input, DATA_WIDTH, adder internal carry chain.
REQ-011 SHALL have port out_valid, output, 1, captured result valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have ports out_sum (output, DATA_WIDTH+1, captured sum) and out_carries (output, DATA_WIDTH, captured carry chain).

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, HOLD.
REQ-015 In IDLE: in_ready=1; on in_valid&in_ready SHALL register in_a/in_b into add_a/add_b, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
REQ-016 In SETTLE: in_ready=0; counter decrements each cycle; at counter 0 SHALL capture add_sum/add_cout_int into out_sum/out_carries and go to HOLD.
REQ-017 Latency SHALL be SETTLE_CYCLES+1 cycles from accepting edge to out_valid=1 (SETTLE_CYCLES=1: capture on first SETTLE cycle).
REQ-018 In HOLD: out_valid=1, out_sum/out_carries stable, add_a/add_b unchanged until handshake.
REQ-019 On out_valid&out_ready SHALL return to IDLE; out_valid drops next cycle.
REQ-020 in_ready SHALL be 1 only in IDLE; no operand accepted same cycle as output handshake (one transaction in flight, throughput 1 per SETTLE_CYCLES+2 cycles minimum).
REQ-021 out_ready held low SHALL stall indefinitely in HOLD with no data loss.
REQ-022 in_valid asserted outside IDLE SHALL be ignored (no state change).
REQ-023 No arithmetic SHALL be performed internally; captured values are the adder's, width DATA_WIDTH+1 with MSB = carry out.

Reset
REQ-024 Asserting reset at any time, including mid-SETTLE or HOLD, SHALL immediately force IDLE, drop any in-flight transaction.
REQ-025 Reset values: in_ready=0 while reset asserted, 1 in first cycle after release; out_valid=0; add_a, add_b, out_sum, out_carries, settle counter all zero.

Configuration
REQ-026 With ADD_SEQUENCER_STATS_EN defined SHALL add output op_count (16 bits), incremented on each output handshake, saturating at 16'hFFFF, reset to 0.
REQ-027 Without ADD_SEQUENCER_STATS_EN, op_count port and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-028 FSM state enum (IDLE, SETTLE, HOLD) and SETTLE_CYCLES default SHALL live in shared package add_seq_pkg.
REQ-029 Settle countdown SHALL be a sub-module settle_timer (load, count, done); adder SHALL remain external, instantiated by the bench/top.

Verification
REQ-030 Bench SHALL connect a real ripple adder (DATA_WIDTH=8, SETTLE_CYCLES=2): in a=8'h0F, b=8'h01 -> out_valid on 3rd edge after accept, out_sum=9'h010, out_carries=8'h0F.
REQ-031 Overflow: a=8'hFF, b=8'h01 -> out_sum=9'h100, out_carries=8'hFF.
REQ-032 Backpressure: out_ready=0 for 10 cycles after a=8'h12, b=8'h34 -> out_sum holds 9'h046, in_ready=0 throughout, new in_valid ignored.
REQ-033 Reset mid-SETTLE (a=8'hAA, b=8'h55, reset at cycle 1) -> out_valid=0, all outputs zero, in_ready=1 after release, next op a=1,b=1 yields 9'h002.
REQ-034 Back-to-back: 4 pairs with out_ready=1 -> each result correct, in order, one per 4 cycles.
REQ-035 With ADD_SEQUENCER_STATS_EN: 5 handshakes -> op_count=5; reset -> op_count=0.
